// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: assembles a 5x5 byte matrix from a byte stream for the MPU transpose stage.
// Latency: 25 accepted bytes + 1 cycle to matrix_valid; in_ready drops while a full matrix waits.
// Backpressure: matrix_ready low holds the full matrix and in_ready low indefinitely.
// Ports: clk/rst_n (sync, active-low); in_data/in_valid/in_ready byte input; flush drops a partial load;
//        matrix/matrix_valid/matrix_ready matrix handoff; fill_count = bytes in current load; abort = timeout pulse.
// Build option: define MPU_LOADER_COLMAJOR_EN to treat the stream as column-major (pre-transposed output).
module mpu_matrix_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [4:0][4:0][7:0] matrix,
  output logic                 matrix_valid,
  input  logic                 matrix_ready,
  output logic [4:0]           fill_count,
  output logic                 abort
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  localparam int unsigned SW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TM1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [SW-1:0] STALL_MAX = SW'(TM1);

  logic [1:0]    state;
  logic          live;       // low from a reset edge until the first edge out of reset
  logic [2:0]    major;      // k / 5, tracked incrementally to avoid a divider
  logic [2:0]    minor;      // k % 5
  logic [SW-1:0] stall_cnt;
  logic          xfer;
  logic          timeout_hit;

  assign in_ready     = live && (state != FULL);
  assign matrix_valid = (state == FULL);
  assign xfer         = in_valid && in_ready;

  // The counter was cleared by the last transfer, so hitting N-1 on an idle
  // cycle means N idle cycles have elapsed at this edge.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == FILL) && !flush && !xfer &&
                       (stall_cnt == STALL_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      live       <= 1'b0;
      fill_count <= 5'd0;
      major      <= 3'd0;
      minor      <= 3'd0;
      stall_cnt  <= '0;
      abort      <= 1'b0;
      matrix     <= '0;
    end else begin
      live  <= 1'b1;
      abort <= 1'b0;
      if (state == FULL) begin
        // flush is ignored here so a completed matrix is never lost
        if (matrix_ready) begin
          state      <= IDLE;
          fill_count <= 5'd0;
          major      <= 3'd0;
          minor      <= 3'd0;
          stall_cnt  <= '0;
        end
      end else if (flush) begin
        state      <= IDLE;
        fill_count <= 5'd0;
        major      <= 3'd0;
        minor      <= 3'd0;
        stall_cnt  <= '0;
      end else if (xfer) begin
`ifdef MPU_LOADER_COLMAJOR_EN
        matrix[minor][major] <= in_data;
`else
        matrix[major][minor] <= in_data;
`endif
        fill_count <= fill_count + 5'd1;
        stall_cnt  <= '0;
        if (minor == 3'd4) begin
          minor <= 3'd0;
          major <= major + 3'd1;
        end else begin
          minor <= minor + 3'd1;
        end
        state <= (fill_count == 5'd24) ? FULL : FILL;
      end else if (timeout_hit) begin
        state      <= IDLE;
        fill_count <= 5'd0;
        major      <= 3'd0;
        minor      <= 3'd0;
        stall_cnt  <= '0;
        abort      <= 1'b1;
      end else if ((TIMEOUT_CYCLES != 0) && (state == FILL)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
module tb_mpu_matrix_loader;

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [4:0][4:0][7:0] matrix;
  logic                 matrix_valid;
  logic                 matrix_ready;
  logic [4:0]           fill_count;
  logic                 abort;

  logic [4:0][4:0][7:0] exp_m;
  int checks = 0;
  int errors = 0;

  mpu_matrix_loader #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .matrix(matrix), .matrix_valid(matrix_valid), .matrix_ready(matrix_ready),
    .fill_count(fill_count), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chkm(input string tag, input logic [4:0][4:0][7:0] obs,
                      input logic [4:0][4:0][7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // record byte k into the expected matrix at the position the build dictates
  task automatic put_exp(input int k, input logic [7:0] v);
`ifdef MPU_LOADER_COLMAJOR_EN
    exp_m[k % 5][k / 5] = v;
`else
    exp_m[k / 5][k % 5] = v;
`endif
  endtask

  // stream n bytes back-to-back; byte k = base + k*inc, starting at element index k0
  task automatic send(input int k0, input int n, input logic [7:0] base, input logic [7:0] inc);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i) * inc;
      put_exp(k0 + i, in_data);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    matrix_ready = 1'b1;
    tick();
    matrix_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; matrix_ready = 1'b0;
    exp_m = '0;
    tick(); tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_matrix_valid", 32'(matrix_valid), 32'd0);
    chk("rst_fill_count", 32'(fill_count), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chkm("rst_matrix", matrix, '0);

    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // bytes 0..24 back-to-back; expected element value = k
    send(0, 24, 8'd0, 8'd1);
    chk("pre_last_fill", 32'(fill_count), 32'd24);
    chk("pre_last_valid", 32'(matrix_valid), 32'd0);
    send(24, 1, 8'd24, 8'd1);
    chk("full_valid", 32'(matrix_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_fill", 32'(fill_count), 32'd25);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
`ifdef MPU_LOADER_COLMAJOR_EN
        chk("elem_colmajor", 32'(matrix[r][c]), 32'(5 * c + r));
`else
        chk("elem_rowmajor", 32'(matrix[r][c]), 32'(5 * r + c));
`endif
      end

    // backpressure for 10 cycles with a byte offered; nothing may change
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chkm("hold_matrix", matrix, exp_m);
      chk("hold_valid", 32'(matrix_valid), 32'd1);
    end
    handoff();
    in_valid = 1'b0;
    chk("handoff_valid", 32'(matrix_valid), 32'd0);
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    chk("handoff_fill", 32'(fill_count), 32'd0);
    chkm("handoff_matrix_kept", matrix, exp_m);

    // partial load then flush with a byte presented: flush wins
    send(0, 7, 8'h50, 8'd1);
    chk("partial_fill", 32'(fill_count), 32'd7);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_fill", 32'(fill_count), 32'd0);
    chk("flush_valid", 32'(matrix_valid), 32'd0);
    send(0, 25, 8'h11, 8'd0);
    chk("reload_valid", 32'(matrix_valid), 32'd1);
    chkm("reload_all_11", matrix, {25{8'h11}});

    // flush while FULL is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_full_valid", 32'(matrix_valid), 32'd1);
    chk("flush_full_fill", 32'(fill_count), 32'd25);
    handoff();

    // timeout: 3 bytes then idle; abort only 4 cycles after the last transfer
    send(0, 3, 8'h30, 8'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("timeout_abort", 32'(abort), 32'((i - 1) == 4));
      chk("timeout_fill", 32'(fill_count), ((i - 1) >= 4) ? 32'd0 : 32'd3);
      tick();
    end

    // short gap (below timeout) freezes state
    send(0, 10, 8'd100, 8'd1);
    tick(); tick();
    chk("gap_fill", 32'(fill_count), 32'd10);
    chk("gap_abort", 32'(abort), 32'd0);

    // reset mid-load after 12 bytes discards everything, no abort
    send(10, 2, 8'd110, 8'd1);
    chk("mid_fill", 32'(fill_count), 32'd12);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chkm("midrst_matrix", matrix, '0);
    chk("midrst_valid", 32'(matrix_valid), 32'd0);
    chk("midrst_fill", 32'(fill_count), 32'd0);
    chk("midrst_abort", 32'(abort), 32'd0);
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_m = '0;
    send(0, 25, 8'd200, 8'd2);
    chk("fresh_valid", 32'(matrix_valid), 32'd1);
    chkm("fresh_matrix", matrix, exp_m);
    chk("fresh_elem_last", 32'(matrix[4][4]), 32'd248);
    handoff();
    chk("fresh_handoff_fill", 32'(fill_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
